digital_clock_param: RTL and testbench
======================================

Name: digital_clock_param

Overview:
- Next-generation BCD time-of-day counter, driven by the system clock instead of a 1 Hz clock.
- An internal prescaler derives the once-per-second advance; a one-cycle TICK pulse marks each advance.
- Adds synchronous time load with digit validation, a 12/24-hour display mode with PM flag, and an HH:MM alarm with sticky flag.
- Sits between the board clock and the display/scan-driver logic.

Parameters:
CLK_DIV, 50000000, system-clock cycles per second (>=2); prescaler width = clog2(CLK_DIV)

Ports:
CLK  input  1  system clock, all state on rising edge
RESET_N  input  1  asynchronous active-low reset
ENABLE  input  1  1 = time runs; 0 = prescaler and time frozen
MODE_12H  input  1  0 = 24-hour display, 1 = 12-hour display
LOAD  input  1  one-cycle strobe: load LD_TIME
LD_TIME  input  24  {h1,h0,m1,m0,s1,s0} BCD, 24-hour format
ALM_WR  input  1  one-cycle strobe: write ALM_TIME
ALM_TIME  input  16  {h1,h0,m1,m0} BCD, 24-hour format
ALM_EN  input  1  alarm compare enable
ALM_CLR  input  1  clears ALARM
sec0, sec1, min0, min1, hour0, hour1  output  4 each  registered BCD time, always 24-hour (00:00:00-23:59:59)
DISP_H1, DISP_H0  output  4 each  display hour digits per MODE_12H, combinational from hour regs
PM  output  1  1 when MODE_12H=1 and hour>=12; else 0
TICK  output  1  registered pulse, high the cycle after each one-second advance
ALARM  output  1  sticky alarm flag
LOAD_ERR  output  1  registered one-cycle pulse on rejected LOAD/ALM_WR

Behaviour:
- Reset (RESET_N low, async):
  - prescaler=0; all time digits 0; alarm register 00:00.
  - TICK=0, ALARM=0, LOAD_ERR=0.
  - Effect is immediate, including mid-second or mid-load.
- Prescaler:
  - While ENABLE=1, counts 0..CLK_DIV-1.
  - On the edge where prescaler==CLK_DIV-1: prescaler wraps to 0, time advances by one second, TICK=1 the following cycle.
  - ENABLE=0 holds prescaler and time; TICK stays 0.
- Time advance (ripple carry, all within one edge):
  - s0 9->0 carries to s1; s1 5->0 carries to m0; m0 9->0 carries to m1; m1 5->0 carries to hours.
  - Hours: 23->00; h0 9->0 with h1+1; otherwise h0+1.
  - 23:59:59 -> 00:00:00 in one advance.
- LOAD:
  - Valid when s0<=9, s1<=5, m0<=9, m1<=5, h0<=9, h1<=2, and (h1<2 or h0<=3).
  - Valid: time := LD_TIME; prescaler := 0; the advance in that cycle is discarded and no TICK follows.
  - LOAD has priority over the advance; LOAD works with ENABLE=0.
  - Invalid: time and prescaler unaffected; LOAD_ERR=1 next cycle.
- ALM_WR:
  - Valid under the same hour/minute rules: alarm reg := ALM_TIME.
  - Invalid: ignored; LOAD_ERR=1 next cycle.
  - LOAD_ERR asserts if either strobe is rejected.
- Alarm set:
  - ALARM sets when an advance (not a LOAD) produces hh:mm:00 equal to the alarm register and ALM_EN=1.
  - ALARM stays set until ALM_CLR.
  - Set and ALM_CLR in the same cycle: set wins.
  - ALM_EN=0 does not clear an already-set ALARM.
- 12-hour mapping (MODE_12H=1):
  - hour 0 -> 12 AM; 1-11 -> same AM; 12 -> 12 PM; 13-23 -> hour-12 PM.
  - DISP_H1 is 0 or 1.
- MODE_12H=0: DISP digits equal hour digits; PM=0.
- Mode is display-only: changing it never alters time registers.

Test Plan:
- CLK_DIV=4, reset, ENABLE=1 -> first TICK on cycle 5 after reset release; sec0=1; TICK period 4 cycles, high width 1 cycle.
- LOAD 23:59:58, run 2 ticks -> 23:59:59 then 00:00:00; at the second tick all digits=0.
- LOAD 09:59:59 then 1 tick -> 10:00:00; LOAD 19:59:59 then 1 tick -> 20:00:00.
- LOAD 24:00:00 and LOAD 12:60:00 -> time unchanged, LOAD_ERR pulse 1 cycle each; ALM_WR 25:00 -> alarm reg unchanged, LOAD_ERR pulse.
- ALM_WR 07:30, ALM_EN=1, LOAD 07:29:58:
  - 2 ticks -> ALARM=1 at 07:30:00; stays 1 through later ticks.
  - ALM_CLR -> 0.
  - ALM_CLR coincident with set -> ALARM=1.
  - LOAD 07:30:00 directly -> ALARM stays 0.
- MODE_12H=1 with hours 00, 11, 12, 13, 23 -> DISP 12/0, 11/0, 12/1, 01/1, 11/1 (PM shown after slash).
- Mid-second: RESET_N low -> immediate all-zero outputs.
- ENABLE=0 for 10 cycles -> no TICK, time frozen.

Source files
------------

// File: rtl/digital_clock_param_if.sv
// Control, load and display signals of the BCD time-of-day counter.
// master = controller/display side, slave = the counter itself.
interface digital_clock_param_if;
  logic        ENABLE;
  logic        MODE_12H;
  logic        LOAD;
  logic [23:0] LD_TIME;
  logic        ALM_WR;
  logic [15:0] ALM_TIME;
  logic        ALM_EN;
  logic        ALM_CLR;
  logic [3:0]  sec0, sec1, min0, min1, hour0, hour1;
  logic [3:0]  DISP_H1, DISP_H0;
  logic        PM;
  logic        TICK;
  logic        ALARM;
  logic        LOAD_ERR;

  modport master (
    output ENABLE, MODE_12H, LOAD, LD_TIME, ALM_WR, ALM_TIME, ALM_EN, ALM_CLR,
    input  sec0, sec1, min0, min1, hour0, hour1, DISP_H1, DISP_H0, PM, TICK, ALARM, LOAD_ERR
  );

  modport slave (
    input  ENABLE, MODE_12H, LOAD, LD_TIME, ALM_WR, ALM_TIME, ALM_EN, ALM_CLR,
    output sec0, sec1, min0, min1, hour0, hour1, DISP_H1, DISP_H0, PM, TICK, ALARM, LOAD_ERR
  );
endinterface

// File: rtl/digital_clock_param.sv
// BCD 24h time-of-day counter advanced once per CLK_DIV system clocks, with validated load,
// HH:MM sticky alarm and 12h display mapping; time/TICK/LOAD_ERR/ALARM update on the next edge.
module digital_clock_param #(
  parameter int CLK_DIV = 50000000
) (
  input logic                  CLK,
  input logic                  RESET_N,
  digital_clock_param_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic [3:0]    s0, s1, m0, m1, h0, h1;
  logic [3:0]    n_s0, n_s1, n_m0, n_m1, n_h0, n_h1;
  logic [15:0]   alm;
  logic          tick_q, alarm_q, err_q;
  logic          adv, ld_ok, alm_ok, ld_take, alm_hit;
  logic [4:0]    hr_bin, disp_bin;
  logic [3:0]    disp_h1, disp_h0;

  function automatic logic hm_valid(input logic [15:0] t);
    return (t[15:12] <= 4'd2) && (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9) &&
           ((t[15:12] < 4'd2) || (t[11:8] <= 4'd3));
  endfunction

  assign adv     = bus.ENABLE && (presc == LAST);
  assign ld_ok   = hm_valid(bus.LD_TIME[23:8]) && (bus.LD_TIME[7:4] <= 4'd5) && (bus.LD_TIME[3:0] <= 4'd9);
  assign alm_ok  = hm_valid(bus.ALM_TIME);
  assign ld_take = bus.LOAD && ld_ok;

  // Full ripple of the one-second advance, so 23:59:59 wraps to 00:00:00 in a single edge.
  always_comb begin
    n_s0 = s0; n_s1 = s1; n_m0 = m0; n_m1 = m1; n_h0 = h0; n_h1 = h1;
    if (s0 != 4'd9) n_s0 = s0 + 4'd1;
    else begin
      n_s0 = 4'd0;
      if (s1 != 4'd5) n_s1 = s1 + 4'd1;
      else begin
        n_s1 = 4'd0;
        if (m0 != 4'd9) n_m0 = m0 + 4'd1;
        else begin
          n_m0 = 4'd0;
          if (m1 != 4'd5) n_m1 = m1 + 4'd1;
          else begin
            n_m1 = 4'd0;
            if (h1 == 4'd2 && h0 == 4'd3) begin
              n_h1 = 4'd0;
              n_h0 = 4'd0;
            end else if (h0 == 4'd9) begin
              n_h0 = 4'd0;
              n_h1 = h1 + 4'd1;
            end else n_h0 = h0 + 4'd1;
          end
        end
      end
    end
  end

  // Only a genuine advance can raise the alarm; a LOAD landing on the alarm time cannot.
  assign alm_hit = adv && !ld_take && bus.ALM_EN && (n_s1 == 4'd0) && (n_s0 == 4'd0) &&
                   ({n_h1, n_h0, n_m1, n_m0} == alm);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc   <= '0;
      s0 <= '0; s1 <= '0; m0 <= '0; m1 <= '0; h0 <= '0; h1 <= '0;
      alm     <= '0;
      tick_q  <= 1'b0;
      alarm_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (ld_take) begin
        presc <= '0;
        {h1, h0, m1, m0, s1, s0} <= bus.LD_TIME;
      end else if (bus.ENABLE) begin
        presc <= adv ? '0 : presc + 1'b1;
        if (adv) {h1, h0, m1, m0, s1, s0} <= {n_h1, n_h0, n_m1, n_m0, n_s1, n_s0};
      end
      if (bus.ALM_WR && alm_ok) alm <= bus.ALM_TIME;
      tick_q  <= adv && !ld_take;
      alarm_q <= alm_hit || (alarm_q && !bus.ALM_CLR);
      err_q   <= (bus.LOAD && !ld_ok) || (bus.ALM_WR && !alm_ok);
    end
  end

  assign hr_bin = 5'(h1) * 5'd10 + 5'(h0);

  always_comb begin
    disp_bin = hr_bin;
    if (hr_bin == 5'd0) disp_bin = 5'd12;
    else if (hr_bin > 5'd12) disp_bin = hr_bin - 5'd12;
    if (!bus.MODE_12H) begin
      disp_h1 = h1;
      disp_h0 = h0;
    end else if (disp_bin >= 5'd10) begin
      disp_h1 = 4'd1;
      disp_h0 = 4'(disp_bin - 5'd10);
    end else begin
      disp_h1 = 4'd0;
      disp_h0 = 4'(disp_bin);
    end
  end

  assign bus.sec0     = s0;
  assign bus.sec1     = s1;
  assign bus.min0     = m0;
  assign bus.min1     = m1;
  assign bus.hour0    = h0;
  assign bus.hour1    = h1;
  assign bus.DISP_H1  = disp_h1;
  assign bus.DISP_H0  = disp_h0;
  assign bus.PM       = bus.MODE_12H && (hr_bin >= 5'd12);
  assign bus.TICK     = tick_q;
  assign bus.ALARM    = alarm_q;
  assign bus.LOAD_ERR = err_q;
endmodule

// File: tb/tb_digital_clock_param.sv
// Directed bench for digital_clock_param with CLK_DIV=4; inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_digital_clock_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  digital_clock_param_if bus();

  digital_clock_param #(.CLK_DIV(4)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] now_t();
    return {bus.hour1, bus.hour0, bus.min1, bus.min0, bus.sec1, bus.sec0};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [23:0] t);
    bus.LD_TIME = t;
    bus.LOAD    = 1'b1;
    step(1);
    bus.LOAD    = 1'b0;
  endtask

  task automatic do_alm(input logic [15:0] a);
    bus.ALM_TIME = a;
    bus.ALM_WR   = 1'b1;
    step(1);
    bus.ALM_WR   = 1'b0;
  endtask

  task automatic test_reset;
    step(2);
    checks++;
    if ({now_t(), bus.TICK, bus.ALARM, bus.LOAD_ERR} !== 27'd0) begin
      errors++;
      $display("FAIL reset_state: got time=%h tick=%b alarm=%b err=%b want all 0", now_t(), bus.TICK, bus.ALARM, bus.LOAD_ERR);
    end
    rst_n = 1'b1;
    step(3);
    checks++;
    if (bus.TICK !== 1'b0 || bus.sec0 !== 4'd0) begin
      errors++;
      $display("FAIL early_tick: got tick=%b sec0=%h want 0/0", bus.TICK, bus.sec0);
    end
    step(1);
    checks++;
    if (bus.TICK !== 1'b1 || bus.sec0 !== 4'd1) begin
      errors++;
      $display("FAIL first_tick: got tick=%b sec0=%h want 1/1", bus.TICK, bus.sec0);
    end
    step(1);
    checks++;
    if (bus.TICK !== 1'b0) begin
      errors++;
      $display("FAIL tick_width: got tick=%b want 0", bus.TICK);
    end
    step(2);
    checks++;
    if (bus.TICK !== 1'b0) begin
      errors++;
      $display("FAIL tick_gap: got tick=%b want 0", bus.TICK);
    end
    step(1);
    checks++;
    if (bus.TICK !== 1'b1 || bus.sec0 !== 4'd2) begin
      errors++;
      $display("FAIL tick_period: got tick=%b sec0=%h want 1/2", bus.TICK, bus.sec0);
    end
  endtask

  task automatic test_rollover;
    step(3);
    do_load(24'h235958);
    checks++;
    if (now_t() !== 24'h235958 || bus.TICK !== 1'b0) begin
      errors++;
      $display("FAIL load_over_advance: got time=%h tick=%b want 235958/0", now_t(), bus.TICK);
    end
    step(4);
    checks++;
    if (now_t() !== 24'h235959 || bus.TICK !== 1'b1) begin
      errors++;
      $display("FAIL roll_235959: got time=%h tick=%b want 235959/1", now_t(), bus.TICK);
    end
    step(4);
    checks++;
    if (now_t() !== 24'h000000 || bus.TICK !== 1'b1) begin
      errors++;
      $display("FAIL roll_midnight: got time=%h tick=%b want 000000/1", now_t(), bus.TICK);
    end
  endtask

  task automatic test_hour_carry;
    do_load(24'h095959);
    step(4);
    checks++;
    if (now_t() !== 24'h100000) begin
      errors++;
      $display("FAIL carry_09_10: got %h want 100000", now_t());
    end
    do_load(24'h195959);
    step(4);
    checks++;
    if (now_t() !== 24'h200000) begin
      errors++;
      $display("FAIL carry_19_20: got %h want 200000", now_t());
    end
  endtask

  task automatic test_invalid_load;
    logic [23:0] bad [2];
    bad[0] = 24'h240000;
    bad[1] = 24'h126000;
    bus.ENABLE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_load(bad[i]);
      checks++;
      if (now_t() !== 24'h200000 || bus.LOAD_ERR !== 1'b1) begin
        errors++;
        $display("FAIL bad_load%0d: got time=%h err=%b want 200000/1", i, now_t(), bus.LOAD_ERR);
      end
      step(1);
      checks++;
      if (bus.LOAD_ERR !== 1'b0) begin
        errors++;
        $display("FAIL bad_load%0d_width: got err=%b want 0", i, bus.LOAD_ERR);
      end
    end
    do_alm(16'h0730);
    checks++;
    if (bus.LOAD_ERR !== 1'b0) begin
      errors++;
      $display("FAIL good_alm_wr: got err=%b want 0", bus.LOAD_ERR);
    end
    do_alm(16'h2500);
    checks++;
    if (bus.LOAD_ERR !== 1'b1) begin
      errors++;
      $display("FAIL bad_alm_wr: got err=%b want 1", bus.LOAD_ERR);
    end
    step(1);
    checks++;
    if (bus.LOAD_ERR !== 1'b0) begin
      errors++;
      $display("FAIL bad_alm_wr_width: got err=%b want 0", bus.LOAD_ERR);
    end
  endtask

  task automatic test_alarm;
    bus.ENABLE = 1'b1;
    bus.ALM_EN = 1'b1;
    do_load(24'h072958);
    step(4);
    checks++;
    if (now_t() !== 24'h072959 || bus.ALARM !== 1'b0) begin
      errors++;
      $display("FAIL alarm_early: got time=%h alarm=%b want 072959/0", now_t(), bus.ALARM);
    end
    step(4);
    checks++;
    if (now_t() !== 24'h073000 || bus.ALARM !== 1'b1) begin
      errors++;
      $display("FAIL alarm_set: got time=%h alarm=%b want 073000/1", now_t(), bus.ALARM);
    end
    step(4);
    checks++;
    if (now_t() !== 24'h073001 || bus.ALARM !== 1'b1) begin
      errors++;
      $display("FAIL alarm_sticky: got time=%h alarm=%b want 073001/1", now_t(), bus.ALARM);
    end
    bus.ALM_EN = 1'b0;
    step(1);
    checks++;
    if (bus.ALARM !== 1'b1) begin
      errors++;
      $display("FAIL alarm_en_off_keeps: got alarm=%b want 1", bus.ALARM);
    end
    bus.ALM_EN  = 1'b1;
    bus.ALM_CLR = 1'b1;
    step(1);
    bus.ALM_CLR = 1'b0;
    checks++;
    if (bus.ALARM !== 1'b0) begin
      errors++;
      $display("FAIL alarm_clr: got alarm=%b want 0", bus.ALARM);
    end
    do_load(24'h072959);
    step(3);
    bus.ALM_CLR = 1'b1;
    step(1);
    bus.ALM_CLR = 1'b0;
    checks++;
    if (now_t() !== 24'h073000 || bus.ALARM !== 1'b1) begin
      errors++;
      $display("FAIL alarm_set_beats_clr: got time=%h alarm=%b want 073000/1", now_t(), bus.ALARM);
    end
    bus.ALM_CLR = 1'b1;
    step(1);
    bus.ALM_CLR = 1'b0;
    do_load(24'h073000);
    checks++;
    if (bus.ALARM !== 1'b0) begin
      errors++;
      $display("FAIL alarm_by_load: got alarm=%b want 0", bus.ALARM);
    end
    step(4);
    checks++;
    if (now_t() !== 24'h073001 || bus.ALARM !== 1'b0) begin
      errors++;
      $display("FAIL alarm_after_load: got time=%h alarm=%b want 073001/0", now_t(), bus.ALARM);
    end
  endtask

  task automatic test_12h;
    logic [23:0] hrs [5];
    logic [3:0]  e_h1 [5];
    logic [3:0]  e_h0 [5];
    logic        e_pm [5];
    hrs  = '{24'h000000, 24'h110000, 24'h120000, 24'h130000, 24'h230000};
    e_h1 = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd1};
    e_h0 = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd1};
    e_pm = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.ENABLE   = 1'b0;
    bus.MODE_12H = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_load(hrs[i]);
      checks++;
      if (bus.DISP_H1 !== e_h1[i] || bus.DISP_H0 !== e_h0[i] || bus.PM !== e_pm[i]) begin
        errors++;
        $display("FAIL disp12_%h: got %h%h pm=%b want %h%h pm=%b", hrs[i][23:16], bus.DISP_H1, bus.DISP_H0, bus.PM, e_h1[i], e_h0[i], e_pm[i]);
      end
    end
    checks++;
    if (now_t() !== 24'h230000) begin
      errors++;
      $display("FAIL mode12_regs: got %h want 230000", now_t());
    end
    bus.MODE_12H = 1'b0;
    #1;
    checks++;
    if (bus.DISP_H1 !== 4'd2 || bus.DISP_H0 !== 4'd3 || bus.PM !== 1'b0 || now_t() !== 24'h230000) begin
      errors++;
      $display("FAIL disp24: got %h%h pm=%b time=%h want 23 pm=0 time=230000", bus.DISP_H1, bus.DISP_H0, bus.PM, now_t());
    end
  endtask

  task automatic test_enable;
    bus.ENABLE = 1'b0;
    do_load(24'h123456);
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (bus.TICK !== 1'b0) begin
        errors++;
        $display("FAIL frozen_tick%0d: got tick=%b want 0", i, bus.TICK);
      end
    end
    checks++;
    if (now_t() !== 24'h123456) begin
      errors++;
      $display("FAIL frozen_time: got %h want 123456", now_t());
    end
    bus.ENABLE = 1'b1;
    step(4);
    checks++;
    if (now_t() !== 24'h123457 || bus.TICK !== 1'b1) begin
      errors++;
      $display("FAIL resume: got time=%h tick=%b want 123457/1", now_t(), bus.TICK);
    end
  endtask

  task automatic test_reset_mid;
    step(2);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({now_t(), bus.TICK, bus.ALARM, bus.LOAD_ERR} !== 27'd0) begin
      errors++;
      $display("FAIL async_reset: got time=%h tick=%b alarm=%b err=%b want all 0", now_t(), bus.TICK, bus.ALARM, bus.LOAD_ERR);
    end
    step(1);
    rst_n = 1'b1;
    step(4);
    checks++;
    if (now_t() !== 24'h000001 || bus.TICK !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_tick: got time=%h tick=%b want 000001/1", now_t(), bus.TICK);
    end
  endtask

  initial begin
    bus.ENABLE   = 1'b1;
    bus.MODE_12H = 1'b0;
    bus.LOAD     = 1'b0;
    bus.LD_TIME  = '0;
    bus.ALM_WR   = 1'b0;
    bus.ALM_TIME = '0;
    bus.ALM_EN   = 1'b0;
    bus.ALM_CLR  = 1'b0;
    test_reset();
    test_rollover();
    test_hour_carry();
    test_invalid_load();
    test_alarm();
    test_12h();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
